// File: rtl/draw_box_regions.sv
// rtl/draw_box_regions.sv - runtime-programmable rectangle overlay hit generator
// Double-buffered box config, two-stage compare/qualify pipeline, frame-based blink.
module draw_box_regions #(
    parameter int N_BOX        = 3,
    parameter int XW           = 11,
    parameter int YW           = 10,
    parameter int IW           = 2,
    parameter int BLINK_FRAMES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [XW-1:0]    gr_x,
    input  logic [YW-1:0]    gr_y,
    input  logic             frame_start,
    input  logic             cfg_we,
    input  logic [IW-1:0]    cfg_idx,
    input  logic [XW-1:0]    cfg_x0,
    input  logic [XW-1:0]    cfg_x1,
    input  logic [YW-1:0]    cfg_y0,
    input  logic [YW-1:0]    cfg_y1,
    input  logic [1:0]       cfg_mode,
    output logic [N_BOX-1:0] box_hit,
    output logic             any_hit,
    output logic [IW-1:0]    box_id,
    output logic             blink_phase
);

    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_FRAMES - 1);

    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_SOLID   = 2'd1;
    localparam logic [1:0] MODE_BLINK   = 2'd2;
    localparam logic [1:0] MODE_OUTLINE = 2'd3;

    logic [XW-1:0] sh_x0_q [N_BOX];
    logic [XW-1:0] sh_x1_q [N_BOX];
    logic [YW-1:0] sh_y0_q [N_BOX];
    logic [YW-1:0] sh_y1_q [N_BOX];
    logic [1:0]    sh_mode_q [N_BOX];
    logic [XW-1:0] ac_x0_q [N_BOX];
    logic [XW-1:0] ac_x1_q [N_BOX];
    logic [YW-1:0] ac_y0_q [N_BOX];
    logic [YW-1:0] ac_y1_q [N_BOX];
    logic [1:0]    ac_mode_q [N_BOX];

    logic [CW-1:0] blink_cnt_q;
    logic          blink_phase_q;

    logic [N_BOX-1:0] ge_x0_d, le_x1_d, ge_y0_d, le_y1_d, edge_d;
    logic [N_BOX-1:0] ge_x0_q, le_x1_q, ge_y0_q, le_y1_q, edge_q;
    logic [1:0]       s1_mode_q [N_BOX];
    logic             s1_en_q;

    logic [N_BOX-1:0] hit_d, hit_q;
    logic             any_d, any_q;
    logic [IW-1:0]    id_d, id_q;

    // A write landing on the same cycle as frame_start goes straight to the active copy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_BOX; i++) begin
                sh_x0_q[i] <= '0; sh_x1_q[i] <= '0;
                sh_y0_q[i] <= '0; sh_y1_q[i] <= '0;
                sh_mode_q[i] <= MODE_OFF;
                ac_x0_q[i] <= '0; ac_x1_q[i] <= '0;
                ac_y0_q[i] <= '0; ac_y1_q[i] <= '0;
                ac_mode_q[i] <= MODE_OFF;
            end
        end else begin
            for (int i = 0; i < N_BOX; i++) begin
                if (cfg_we && cfg_idx == IW'(i)) begin
                    sh_x0_q[i] <= cfg_x0; sh_x1_q[i] <= cfg_x1;
                    sh_y0_q[i] <= cfg_y0; sh_y1_q[i] <= cfg_y1;
                    sh_mode_q[i] <= cfg_mode;
                end
                if (frame_start) begin
                    if (cfg_we && cfg_idx == IW'(i)) begin
                        ac_x0_q[i] <= cfg_x0; ac_x1_q[i] <= cfg_x1;
                        ac_y0_q[i] <= cfg_y0; ac_y1_q[i] <= cfg_y1;
                        ac_mode_q[i] <= cfg_mode;
                    end else begin
                        ac_x0_q[i] <= sh_x0_q[i]; ac_x1_q[i] <= sh_x1_q[i];
                        ac_y0_q[i] <= sh_y0_q[i]; ac_y1_q[i] <= sh_y1_q[i];
                        ac_mode_q[i] <= sh_mode_q[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
        end else if (frame_start) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_q   <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        ge_x0_d = '0; le_x1_d = '0; ge_y0_d = '0; le_y1_d = '0; edge_d = '0;
        for (int i = 0; i < N_BOX; i++) begin
            ge_x0_d[i] = (gr_x >= ac_x0_q[i]);
            le_x1_d[i] = (gr_x <= ac_x1_q[i]);
            ge_y0_d[i] = (gr_y >= ac_y0_q[i]);
            le_y1_d[i] = (gr_y <= ac_y1_q[i]);
            edge_d[i]  = (gr_x == ac_x0_q[i]) || (gr_x == ac_x1_q[i]) ||
                         (gr_y == ac_y0_q[i]) || (gr_y == ac_y1_q[i]);
        end
    end

    // Mode is captured alongside the compares so a commit can't split a pixel's config.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ge_x0_q <= '0; le_x1_q <= '0; ge_y0_q <= '0; le_y1_q <= '0; edge_q <= '0;
            for (int i = 0; i < N_BOX; i++) s1_mode_q[i] <= MODE_OFF;
            s1_en_q <= 1'b0;
        end else begin
            ge_x0_q <= ge_x0_d; le_x1_q <= le_x1_d;
            ge_y0_q <= ge_y0_d; le_y1_q <= le_y1_d;
            edge_q  <= edge_d;
            for (int i = 0; i < N_BOX; i++) s1_mode_q[i] <= ac_mode_q[i];
            s1_en_q <= enable;
        end
    end

    always_comb begin
        hit_d = '0;
        id_d  = '0;
        for (int i = 0; i < N_BOX; i++) begin
            if (s1_en_q && ge_x0_q[i] && le_x1_q[i] && ge_y0_q[i] && le_y1_q[i]) begin
                case (s1_mode_q[i])
                    MODE_SOLID:   hit_d[i] = 1'b1;
                    MODE_BLINK:   hit_d[i] = blink_phase_q;
                    MODE_OUTLINE: hit_d[i] = edge_q[i];
                    default:      hit_d[i] = 1'b0;
                endcase
            end
        end
        any_d = |hit_d;
        for (int i = N_BOX - 1; i >= 0; i--) begin
            if (hit_d[i]) id_d = IW'(i);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_q <= '0;
            any_q <= 1'b0;
            id_q  <= '0;
        end else begin
            hit_q <= hit_d;
            any_q <= any_d;
            id_q  <= id_d;
        end
    end

    assign box_hit     = hit_q;
    assign any_hit     = any_q;
    assign box_id      = id_q;
    assign blink_phase = blink_phase_q;

endmodule

// File: doc/draw_box_regions.md
# draw_box_regions

Parametrised rectangle-overlay generator for the VGA video path. It compares the current raster coordinate against N_BOX runtime-programmable rectangles and emits per-box hit flags, an any-hit flag and the lowest-index hit ID. Each box can be off, solid, blinking or outline-only. It sits between the raster coordinate generator and the pixel mux. It replaces fixed-coordinate, three-box region decoding, such as the count-threshold number boxes.

## Interface
- N_BOX, 3: number of rectangles (1..16)
- XW, 11: x coordinate width
- YW, 10: y coordinate width
- IW, 2: box index width, must satisfy 2^IW >= N_BOX
- BLINK_FRAMES, 16: frames per blink half-period (>=1)
- clk  in  1  pixel clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  active-video qualifier for gr_x/gr_y
- gr_x  in  XW  current pixel column
- gr_y  in  YW  current pixel row
- frame_start  in  1  one-cycle pulse at start of each frame (vertical blank)
- cfg_we  in  1  write strobe for box configuration
- cfg_idx  in  IW  box index being written; writes with cfg_idx >= N_BOX are ignored
- cfg_x0, cfg_x1  in  XW  inclusive left/right bounds
- cfg_y0, cfg_y1  in  YW  inclusive top/bottom bounds
- cfg_mode  in  2  0 off, 1 solid, 2 blink, 3 outline
- box_hit  out  N_BOX  per-box hit, bit i = box i
- any_hit  out  1  OR of box_hit
- box_id  out  IW  lowest index with box_hit set; 0 when none
- blink_phase  out  1  current blink phase (1 = visible)

## Operation
- Configuration is double-buffered. A cfg_we write updates the shadow copy of box cfg_idx. The active copy is loaded from the shadow on frame_start, so boxes never tear mid-frame.
- When cfg_we and frame_start coincide, the active copy receives the value being written that cycle (write-through commit).
- Box i is "inside" when x0<=gr_x<=x1 and y0<=gr_y<=y1, using unsigned compares.
- If x0>x1 or y0>y1, the box never hits in any mode.
- Hit rule by mode:
  - off: 0
  - solid: inside
  - blink: inside AND blink_phase
  - outline: inside AND (gr_x==x0 OR gr_x==x1 OR gr_y==y0 OR gr_y==y1)
- If enable=0, all hits for that pixel are 0. The enable value travels with the pixel through the pipeline.
- Blink counter:
  - Counts frame_start pulses from 0 to BLINK_FRAMES-1.
  - On the pulse that arrives with the count at BLINK_FRAMES-1, the count wraps to 0 and blink_phase toggles.
  - The new phase applies from the cycle after that pulse.
- box_id uses a fixed priority encoder; box 0 has the highest priority.

## Timing
- Pipeline latency is 2 cycles from gr_x/gr_y/enable to box_hit/any_hit/box_id.
  - Stage 1 registers the four bound compares per box plus enable.
  - Stage 2 registers the mode-qualified hits, any_hit and box_id.
- Throughput is one pixel per clock with no stalls.
- Config commit: a pixel sampled in the cycle after frame_start uses the new active config. Its output appears 2 cycles later.
- Reset values:
  - box_hit=0, any_hit=0, box_id=0.
  - blink_phase=1, blink counter=0.
  - All shadow and active boxes: mode off, coordinates 0.
- reset_n assertion clears all state asynchronously, including pipeline contents and config, regardless of in-flight pixels. Outputs are 0 while reset_n is low.
- After deassertion, the first valid output appears 2 cycles after the first sampled pixel.
- A cfg_we write alone never changes outputs before the next frame_start.

## Test plan
- Solid box, boundaries:
  - Stimulus: box0 = x 56..145, y 149..228, mode 1, then frame_start.
  - Sweep x 55..146 at y=149. Also check (145,228) and (145,229).
  - Required: box_hit[0]=1 exactly for x 56..145, 2 cycles after each sample. (145,228) hits; (145,229) does not.
- Overlap and priority:
  - Stimulus: box1 = 0..100 and box2 = 50..150 in x, both with y 0..10 and mode 1. Pixel (75,5).
  - Required: box_hit=3'b110, any_hit=1, box_id=1.
  - Pixel (120,5): box_id=2. Pixel (200,5): any_hit=0, box_id=0.
- Outline and inverted box:
  - Stimulus: box0 = 10..20 x 10..20, mode 3. Also a box with x0=30, x1=20.
  - Required for box0: (10,15) and (15,20) hit; (15,15) misses.
  - Required for the inverted box: never hits.
- Blink with BLINK_FRAMES=2:
  - Stimulus: mode 2 box covering the pixel; issue 6 frame_start pulses.
  - Required: blink_phase sequence 1,1,0,0,1,1 across the frames. Hits occur only in frames where blink_phase=1.
- Double buffering:
  - Stimulus: write box0 mid-frame to move it from x 56 to x 256.
  - Required: hits remain at x 56 until frame_start, then occur at x 256.
  - A write coincident with frame_start takes effect immediately.
  - cfg_idx=3 with N_BOX=3 changes nothing.
- Reset and enable:
  - Stimulus: assert reset_n=0 mid-line while hits are in flight.
  - Required: outputs clear immediately, all boxes read back as off, blink_phase=1.
  - enable=0 over a solid box gives zero hits with 2-cycle alignment.
